// File: rtl/rr_tdm_pkg.sv
// Shared types and helpers for the round-robin / TDM multiplier engine.
package rr_tdm_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_WORK  = 1'b1
    } tdm_mode_e;

    // Channel-index width, never narrower than one bit.
    function automatic int ch_idx_width(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-pointer arbiter: fixed-slot TDM or work-conserving round robin.
module rr_arbiter
    import rr_tdm_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = ch_idx_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  tdm_mode_e         mode,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [CH_W-1:0]   grant,
    output logic [NUM_CH-1:0] grant_onehot,
    output logic              grant_valid
);

    logic [CH_W-1:0] ptr_reg;
    logic [CH_W-1:0] ptr_next;
    logic [CH_W-1:0] work_grant;
    logic            work_hit;

    logic [CH_W:0]   cand_sum [NUM_CH];
    logic [CH_W-1:0] cand_idx [NUM_CH];

    function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] idx);
        return (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Candidate gi is the channel gi positions after the pointer, modulo NUM_CH.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, ptr_reg} + (CH_W+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (CH_W+1)'(NUM_CH))
                                ? CH_W'(cand_sum[gi] - (CH_W+1)'(NUM_CH))
                                : CH_W'(cand_sum[gi]);
        end
    endgenerate

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        work_grant = ptr_reg;
        work_hit   = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                work_grant = cand_idx[k];
                work_hit   = 1'b1;
            end
        end
    end

    always_comb begin
        grant       = ptr_reg;
        grant_valid = 1'b1;
        if (mode == MODE_WORK) begin
            grant       = work_grant;
            grant_valid = work_hit;
        end
    end

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_onehot
            assign grant_onehot[gi] = grant_valid && (grant == CH_W'(gi));
        end
    endgenerate

    always_comb begin
        ptr_next = ptr_reg;
        if (advance) begin
            if (mode == MODE_FIXED)
                ptr_next = wrap_inc(ptr_reg);
            else if (work_hit)
                ptr_next = wrap_inc(work_grant);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_reg <= '0;
        else
            ptr_reg <= ptr_next;
    end

endmodule

// File: rtl/rr_tdm_mult_arb.sv
// N-channel time-division multiplier: arbiter feeding a 3-stage A/M/P multiply
// pipeline with tagged, backpressured output and an empty-slot counter.
module rr_tdm_mult_arb
    import rr_tdm_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int COEF_WIDTH = 8,
    parameter  int CNT_WIDTH  = 16,
    localparam int CH_W       = ch_idx_width(NUM_CH),
    localparam int PROD_W     = DATA_WIDTH + COEF_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH*COEF_WIDTH-1:0] in_coef,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    output logic [PROD_W-1:0]            out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CNT_WIDTH-1:0]         miss_count
);

    tdm_mode_e             mode_e;
    logic                  stall;
    logic                  accept;
    logic [CH_W-1:0]       grant;
    logic [NUM_CH-1:0]     grant_onehot;
    logic                  grant_valid;

    logic [DATA_WIDTH-1:0] data_ch [NUM_CH];
    logic [COEF_WIDTH-1:0] coef_ch [NUM_CH];

    logic                  s1_valid_reg;
    logic [DATA_WIDTH-1:0] s1_data_reg;
    logic [COEF_WIDTH-1:0] s1_coef_reg;
    logic [CH_W-1:0]       s1_ch_reg;
    logic                  s2_valid_reg;
    logic [PROD_W-1:0]     s2_prod_reg;
    logic [CH_W-1:0]       s2_ch_reg;
    logic                  out_valid_reg;
    logic [PROD_W-1:0]     out_data_reg;
    logic [CH_W-1:0]       out_ch_reg;
    logic [CNT_WIDTH-1:0]  miss_count_reg;

    assign mode_e = tdm_mode_e'(mode);
    assign stall  = out_valid_reg & ~out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign data_ch[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign coef_ch[gi] = in_coef[gi*COEF_WIDTH +: COEF_WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode_e),
        .req          (in_valid),
        .advance      (~stall),
        .grant        (grant),
        .grant_onehot (grant_onehot),
        .grant_valid  (grant_valid)
    );

    assign in_ready = (rst || stall) ? '0 : grant_onehot;
    assign accept   = |(in_valid & in_ready);

    // The whole pipeline freezes on stall; bubbles are not squeezed out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_data_reg    <= '0;
            s1_coef_reg    <= '0;
            s1_ch_reg      <= '0;
            s2_valid_reg   <= 1'b0;
            s2_prod_reg    <= '0;
            s2_ch_reg      <= '0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_ch_reg     <= '0;
            miss_count_reg <= '0;
        end else if (!stall) begin
            s1_valid_reg  <= accept;
            s1_data_reg   <= data_ch[grant];
            s1_coef_reg   <= coef_ch[grant];
            s1_ch_reg     <= grant;
            s2_valid_reg  <= s1_valid_reg;
            s2_prod_reg   <= PROD_W'(s1_data_reg) * PROD_W'(s1_coef_reg);
            s2_ch_reg     <= s1_ch_reg;
            out_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                out_data_reg <= s2_prod_reg;
                out_ch_reg   <= s2_ch_reg;
            end
            if (mode_e == MODE_FIXED && !in_valid[grant] && miss_count_reg != '1)
                miss_count_reg <= miss_count_reg + 1'b1;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_ch     = out_ch_reg;
    assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_rr_tdm_mult_arb.sv
// Directed bench: 4-channel engine (work/fixed/stall/width/reset) and a
// 3-channel engine with a 4-bit miss counter (wrap, mode switch, saturation).
module tb_rr_tdm_mult_arb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic        rst, mode, out_ready, out_valid;
    logic [31:0] in_data, in_coef;
    logic [3:0]  in_valid, in_ready;
    logic [15:0] out_data, miss_count;
    logic [1:0]  out_ch;

    // 3-channel instance, small counter so saturation is reachable quickly
    logic        rst3, mode3, out_ready3, out_valid3;
    logic [23:0] in_data3, in_coef3;
    logic [2:0]  in_valid3, in_ready3;
    logic [15:0] out_data3;
    logic [3:0]  miss_count3;
    logic [1:0]  out_ch3;

    int checks = 0;
    int errors = 0;

    rr_tdm_mult_arb dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_data(in_data), .in_coef(in_coef),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready),
        .miss_count(miss_count)
    );

    rr_tdm_mult_arb #(.NUM_CH(3), .CNT_WIDTH(4)) dut3 (
        .clk(clk), .rst(rst3), .mode(mode3),
        .in_data(in_data3), .in_coef(in_coef3),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .miss_count(miss_count3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int idx, input logic [7:0] d, input logic [7:0] c);
        in_data[idx*8 +: 8] = d;
        in_coef[idx*8 +: 8] = c;
    endtask

    task automatic set_ch3(input int idx, input logic [7:0] d, input logic [7:0] c);
        in_data3[idx*8 +: 8] = d;
        in_coef3[idx*8 +: 8] = c;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] ch, input logic [15:0] d);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".ch"},    32'(out_ch),    32'(ch));
        check({tag, ".data"},  32'(out_data),  32'(d));
    endtask

    task automatic check_out3(input string tag, input logic [1:0] ch, input logic [15:0] d);
        check({tag, ".valid"}, 32'(out_valid3), 32'd1);
        check({tag, ".ch"},    32'(out_ch3),    32'(ch));
        check({tag, ".data"},  32'(out_data3),  32'(d));
    endtask

    // Fixed-mode window, edges 18..24, ptr starting at 2 with only ch2 valid
    logic [3:0]  fx_rdy  [7] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [15:0] fx_miss [7] = '{0, 1, 2, 3, 3, 4, 5};
    logic        fx_ov   [7] = '{1, 1, 1, 0, 0, 0, 1};
    logic [1:0]  fx_ch   [7] = '{1, 1, 2, 2, 2, 2, 2};
    logic [15:0] fx_data [7] = '{65025, 65025, 63, 63, 63, 63, 63};

    initial begin
        rst = 1'b1; mode = 1'b1; out_ready = 1'b1;
        in_data = '0; in_coef = '0; in_valid = 4'b1010;
        set_ch(1, 8'd3, 8'd2);
        set_ch(3, 8'd5, 8'd10);
        rst3 = 1'b1; mode3 = 1'b1; out_ready3 = 1'b1;
        in_data3 = '0; in_coef3 = '0; in_valid3 = 3'b111;
        set_ch3(0, 8'd1, 8'd10);
        set_ch3(1, 8'd2, 8'd10);
        set_ch3(2, 8'd3, 8'd10);

        // Reset state, with requests already present
        tick; tick;
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check_out("rst.out", 1'b0, 2'd0, 16'd0);
        check("rst.miss", 32'(miss_count), 32'd0);

        // Work mode, ch1 (3*2) and ch3 (5*10) alternate
        rst = 1'b0;
        #1;
        check("work.c0.ready", 32'(in_ready), 32'b0010);
        for (int n = 1; n <= 6; n++) begin
            tick;
            check($sformatf("work.e%0d.ready", n), 32'(in_ready), (n % 2 == 1) ? 32'b1000 : 32'b0010);
            if (n < 3)
                check($sformatf("work.e%0d.valid", n), 32'(out_valid), 32'd0);
            else
                check_out($sformatf("work.e%0d", n), 1'b1, (n % 2 == 1) ? 2'd1 : 2'd3,
                          (n % 2 == 1) ? 16'd6 : 16'd50);
        end

        // Backpressure for 5 edges: everything holds
        out_ready = 1'b0;
        #1;
        check("stall.ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick;
            check_out($sformatf("stall.%0d", i), 1'b1, 2'd3, 16'd50);
            check($sformatf("stall.%0d.ready", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("unstall.ready", 32'(in_ready), 32'b0010);
        for (int n = 12; n <= 14; n++) begin
            tick;
            check($sformatf("resume.e%0d.ready", n), 32'(in_ready), (n % 2 == 0) ? 32'b1000 : 32'b0010);
            check_out($sformatf("resume.e%0d", n), 1'b1, (n % 2 == 0) ? 2'd1 : 2'd3,
                      (n % 2 == 0) ? 16'd6 : 16'd50);
        end

        // Width corner: only ch1, 255*255
        in_valid = 4'b0010;
        set_ch(1, 8'd255, 8'd255);
        #1;
        check("wide.ready", 32'(in_ready), 32'b0010);
        tick; check_out("wide.e15", 1'b1, 2'd3, 16'd50);
        tick; check_out("wide.e16", 1'b1, 2'd1, 16'd6);
        tick; check_out("wide.e17", 1'b1, 2'd1, 16'd65025);

        // Fixed mode, only ch2 valid (7*9), ptr currently 2
        mode = 1'b0;
        in_valid = 4'b0100;
        set_ch(2, 8'd7, 8'd9);
        #1;
        check("fixed.c17.ready", 32'(in_ready), 32'b0100);
        for (int i = 0; i < 7; i++) begin
            tick;
            check($sformatf("fixed.e%0d.ready", i + 18), 32'(in_ready), 32'(fx_rdy[i]));
            check($sformatf("fixed.e%0d.miss", i + 18), 32'(miss_count), 32'(fx_miss[i]));
            check_out($sformatf("fixed.e%0d", i + 18), fx_ov[i], fx_ch[i], fx_data[i]);
        end

        // Asynchronous reset with a result on the output
        #1;
        rst = 1'b1;
        #1;
        check("arst.in_ready", 32'(in_ready), 32'd0);
        check_out("arst.out", 1'b0, 2'd0, 16'd0);
        check("arst.miss", 32'(miss_count), 32'd0);
        mode = 1'b1;
        in_valid = 4'b1111;
        set_ch(0, 8'd4, 8'd4);
        tick;
        check("arst.hold.valid", 32'(out_valid), 32'd0);
        check("arst.hold.ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst.ready", 32'(in_ready), 32'b0001);
        tick; check("post_rst.e1.valid", 32'(out_valid), 32'd0);
        tick; check("post_rst.e2.valid", 32'(out_valid), 32'd0);
        tick; check_out("post_rst.e3", 1'b1, 2'd0, 16'd16);

        // 3 channels, work mode, all valid: products 10/20/30, ptr wraps 2->0
        rst3 = 1'b0;
        #1;
        check("n3.c0.ready", 32'(in_ready3), 32'b001);
        tick; check("n3.e1.ready", 32'(in_ready3), 32'b010);
        tick; check("n3.e2.ready", 32'(in_ready3), 32'b100);
        tick; check("n3.e3.ready", 32'(in_ready3), 32'b001);
        check_out3("n3.e3", 2'd0, 16'd10);
        tick; check("n3.e4.ready", 32'(in_ready3), 32'b010);
        check_out3("n3.e4", 2'd1, 16'd20);

        // Switch to fixed mid-stream: grants continue from ptr=1
        mode3 = 1'b0;
        #1;
        check("n3.fixed.c4.ready", 32'(in_ready3), 32'b010);
        tick; check("n3.e5.ready", 32'(in_ready3), 32'b100);
        check_out3("n3.e5", 2'd2, 16'd30);
        tick; check("n3.e6.ready", 32'(in_ready3), 32'b001);
        check_out3("n3.e6", 2'd0, 16'd10);
        tick; check_out3("n3.e7", 2'd1, 16'd20);
        tick; check_out3("n3.e8", 2'd2, 16'd30);
        check("n3.e8.miss", 32'(miss_count3), 32'd0);

        // Empty slots every cycle: 4-bit counter saturates at 15
        in_valid3 = 3'b000;
        repeat (14) tick;
        check("n3.miss14", 32'(miss_count3), 32'd14);
        tick;
        check("n3.miss15", 32'(miss_count3), 32'd15);
        repeat (3) tick;
        check("n3.miss_sat", 32'(miss_count3), 32'd15);
        check("n3.drain.valid", 32'(out_valid3), 32'd0);
        check("n3.drain.ch", 32'(out_ch3), 32'd1);
        check("n3.drain.data", 32'(out_data3), 32'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
